// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO with on-block storage, registered read port, optional
// first-word-fall-through, programmable almost flags and sticky error flags.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_EN,
  input  logic [DATA_WIDTH-1:0] W_Data,
  input  logic                  R_EN,
  output logic [DATA_WIDTH-1:0] R_Data,
  output logic                  R_Valid,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  load_head;

  // In FWFT mode COUNT includes the output register, so the array may still
  // hold words while R_Valid is low; pointer inequality tracks the array alone.
  always_comb begin
    rd_accept  = R_EN && (FWFT ? R_Valid : !EMPTY);
    wr_accept  = W_EN && (!FULL || rd_accept);
    load_head  = FWFT ? ((!R_Valid || rd_accept) && (wptr != rptr)) : rd_accept;
    count_next = COUNT;
    if (wr_accept && !rd_accept)      count_next = COUNT + ONE;
    else if (rd_accept && !wr_accept) count_next = COUNT - ONE;
  end

  // NOTE: the storage array has no reset; pointers define validity, and a
  // reset-free array maps onto plain RAM instead of thousands of flops.
  always_ff @(posedge CLK) begin
    if (wr_accept && !RST) mem[wptr[ADDR_WIDTH-1:0]] <= W_Data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; reading mem here therefore never sees a same-edge write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr         <= '0;
      rptr         <= '0;
      R_Data       <= '0;
      R_Valid      <= 1'b0;
      COUNT        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      if (wr_accept) wptr <= wptr + ONE;
      if (load_head) begin
        R_Data <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr   <= rptr + ONE;
      end
      R_Valid      <= FWFT ? (load_head || (R_Valid && !rd_accept)) : rd_accept;
      COUNT        <= count_next;
      FULL         <= (count_next == DEPTH_C);
      EMPTY        <= (count_next == '0);
      ALMOST_FULL  <= (count_next >= AF_C);
      ALMOST_EMPTY <= (count_next <= AE_C);
      if (W_EN && !wr_accept) OVERFLOW  <= 1'b1;
      if (R_EN && !rd_accept) UNDERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Directed bench for sync_fifo_mem: one standard-mode and one FWFT instance,
// each tracked by a behavioural model with a data scoreboard queue.
module tb_sync_fifo_mem;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       s_wen, s_ren, f_wen, f_ren;
  logic [7:0] s_wd, f_wd;
  logic [7:0] s_rdata, f_rdata;
  logic       s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  sync_fifo_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b0)) u_std (
    .CLK(clk), .RST(rst), .W_EN(s_wen), .W_Data(s_wd), .R_EN(s_ren),
    .R_Data(s_rdata), .R_Valid(s_rvalid), .FULL(s_full), .EMPTY(s_empty),
    .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae), .COUNT(s_count),
    .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
  );

  sync_fifo_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b1)) u_fwft (
    .CLK(clk), .RST(rst), .W_EN(f_wen), .W_Data(f_wd), .R_EN(f_ren),
    .R_Data(f_rdata), .R_Valid(f_rvalid), .FULL(f_full), .EMPTY(f_empty),
    .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae), .COUNT(f_count),
    .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Standard-mode model
  logic [7:0] sq[$];
  int         m_s_cnt;
  bit         m_s_ovf, m_s_udf;
  logic [7:0] m_s_last;

  // FWFT model: fq holds words still in the array, m_f_head is the output word
  logic [7:0] fq[$];
  int         m_f_cnt;
  bit         m_f_ovf, m_f_udf, m_f_rv;
  logic [7:0] m_f_head;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic std_flags();
    check("s_count", s_count, m_s_cnt);
    check("s_full",  s_full,  m_s_cnt == 16);
    check("s_empty", s_empty, m_s_cnt == 0);
    check("s_af",    s_af,    m_s_cnt >= 12);
    check("s_ae",    s_ae,    m_s_cnt <= 4);
    check("s_ovf",   s_ovf,   m_s_ovf);
    check("s_udf",   s_udf,   m_s_udf);
  endtask

  task automatic fw_flags();
    check("f_count", f_count, m_f_cnt);
    check("f_full",  f_full,  m_f_cnt == 16);
    check("f_empty", f_empty, m_f_cnt == 0);
    check("f_af",    f_af,    m_f_cnt >= 12);
    check("f_ae",    f_ae,    m_f_cnt <= 4);
    check("f_ovf",   f_ovf,   m_f_ovf);
    check("f_udf",   f_udf,   m_f_udf);
  endtask

  task automatic std_cycle(input logic wen, input logic [7:0] wd, input logic ren);
    bit rd_acc, wr_acc;
    rd_acc = ren && (m_s_cnt > 0);
    wr_acc = wen && ((m_s_cnt < 16) || rd_acc);
    if (wen && !wr_acc) m_s_ovf = 1'b1;
    if (ren && !rd_acc) m_s_udf = 1'b1;
    if (wr_acc) sq.push_back(wd);
    m_s_cnt = m_s_cnt + int'(wr_acc) - int'(rd_acc);
    s_wen = wen; s_wd = wd; s_ren = ren;
    step();
    s_wen = 1'b0; s_ren = 1'b0;
    check("s_rvalid", s_rvalid, rd_acc);
    if (rd_acc) m_s_last = sq.pop_front();
    check("s_rdata", s_rdata, m_s_last);
    std_flags();
  endtask

  task automatic fw_cycle(input logic wen, input logic [7:0] wd, input logic ren);
    bit rd_acc, wr_acc;
    rd_acc = ren && m_f_rv;
    wr_acc = wen && ((m_f_cnt < 16) || rd_acc);
    if (wen && !wr_acc) m_f_ovf = 1'b1;
    if (ren && !rd_acc) m_f_udf = 1'b1;
    m_f_cnt = m_f_cnt + int'(wr_acc) - int'(rd_acc);
    // The head register refills only from words written on earlier edges.
    if ((!m_f_rv || rd_acc) && (fq.size() > 0)) begin
      m_f_head = fq.pop_front();
      m_f_rv   = 1'b1;
    end else if (rd_acc) begin
      m_f_rv = 1'b0;
    end
    if (wr_acc) fq.push_back(wd);
    f_wen = wen; f_wd = wd; f_ren = ren;
    step();
    f_wen = 1'b0; f_ren = 1'b0;
    check("f_rvalid", f_rvalid, m_f_rv);
    check("f_rdata",  f_rdata,  m_f_head);
    fw_flags();
  endtask

  // Reset with both request inputs asserted, so RST priority is exercised too.
  task automatic do_reset();
    rst = 1'b1;
    s_wen = 1'b1; s_ren = 1'b1; s_wd = 8'hEE;
    f_wen = 1'b1; f_ren = 1'b1; f_wd = 8'hEE;
    step();
    rst = 1'b0;
    s_wen = 1'b0; s_ren = 1'b0; f_wen = 1'b0; f_ren = 1'b0;
    sq.delete(); fq.delete();
    m_s_cnt = 0; m_s_ovf = 1'b0; m_s_udf = 1'b0; m_s_last = 8'h00;
    m_f_cnt = 0; m_f_ovf = 1'b0; m_f_udf = 1'b0; m_f_rv = 1'b0; m_f_head = 8'h00;
    check("s_rst_rvalid", s_rvalid, 1'b0);
    check("s_rst_rdata",  s_rdata,  8'h00);
    std_flags();
    check("f_rst_rvalid", f_rvalid, 1'b0);
    check("f_rst_rdata",  f_rdata,  8'h00);
    fw_flags();
  endtask

  initial begin
    rst = 1'b1;
    s_wen = 1'b0; s_ren = 1'b0; s_wd = 8'h00;
    f_wen = 1'b0; f_ren = 1'b0; f_wd = 8'h00;
    step();

    // Standard mode: reset, idle, fill, overflow, drain, underflow
    do_reset();
    std_cycle(1'b0, 8'h00, 1'b0);
    std_cycle(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 16; i++) std_cycle(1'b1, 8'(i), 1'b0);
    std_cycle(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 16; i++) std_cycle(1'b0, 8'h00, 1'b1);
    std_cycle(1'b0, 8'h00, 1'b1);
    std_cycle(1'b0, 8'h00, 1'b0);
    std_cycle(1'b1, 8'h77, 1'b0);
    std_cycle(1'b0, 8'h00, 1'b1);
    check("s_ovf_sticky", s_ovf, 1'b1);
    check("s_udf_sticky", s_udf, 1'b1);

    // Simultaneous requests at full and at empty, across pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) std_cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) std_cycle(1'b1, 8'(8'h80 + i), 1'b1);
    check("s_full_no_ovf", s_ovf, 1'b0);
    for (int i = 0; i < 16; i++) std_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) std_cycle(1'b1, 8'(8'hC0 + i), 1'b1);
    check("s_empty_both_count", s_count, 5'd1);
    std_cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-burst at COUNT=7, then only new data comes back
    do_reset();
    for (int i = 0; i < 7; i++) std_cycle(1'b1, 8'(8'h10 + i), 1'b0);
    check("s_pre_rst_count", s_count, 5'd7);
    do_reset();
    std_cycle(1'b1, 8'h31, 1'b0);
    std_cycle(1'b1, 8'h32, 1'b0);
    std_cycle(1'b0, 8'h00, 1'b1);
    check("s_new_data0", s_rdata, 8'h31);
    std_cycle(1'b0, 8'h00, 1'b1);
    check("s_new_data1", s_rdata, 8'h32);

    // FWFT mode: first-word latency, back-to-back pops, underflow
    do_reset();
    fw_cycle(1'b1, 8'h5A, 1'b0);
    check("f_first_lat_rv", f_rvalid, 1'b0);
    fw_cycle(1'b0, 8'h00, 1'b0);
    check("f_first_word", f_rdata, 8'h5A);
    fw_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 8; i++) fw_cycle(1'b1, 8'(i), 1'b0);
    fw_cycle(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) fw_cycle(1'b0, 8'h00, 1'b1);
    fw_cycle(1'b0, 8'h00, 1'b1);

    // FWFT full/empty simultaneous traffic
    do_reset();
    for (int i = 0; i < 16; i++) fw_cycle(1'b1, 8'(8'h20 + i), 1'b0);
    fw_cycle(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 40; i++) fw_cycle(1'b1, 8'(8'h90 + i), 1'b1);
    for (int i = 0; i < 16; i++) fw_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) fw_cycle(1'b1, 8'(8'hD0 + i), 1'b1);
    for (int i = 0; i < 3; i++) fw_cycle(1'b0, 8'h00, 1'b1);

    // FWFT reset mid-burst
    do_reset();
    for (int i = 0; i < 7; i++) fw_cycle(1'b1, 8'(8'h60 + i), 1'b0);
    do_reset();
    fw_cycle(1'b1, 8'h3C, 1'b0);
    fw_cycle(1'b0, 8'h00, 1'b0);
    check("f_new_data", f_rdata, 8'h3C);
    fw_cycle(1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
